ad9361_dual_tx_axis: RTL and testbench

AD9361_DUAL_TX_AXIS -- requirements
Module: ad9361_dual_tx_axis

---
 rtl/ad9361_dual_tx_axis.sv | 201 ++++++++++++++++++++
 tb/tb_ad9361_dual_tx_axis.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_dual_tx_axis.sv
// AD9361 dual-channel transmit sample feeder.
// An AXI-Stream source of 128-bit beats fills a small FIFO; the CMOS transmit
// interface pulls one beat per tx_req and gets eight 12-bit samples
// (I/Q for channels 0..3) one cycle later with a valid strobe per channel.
// Optional feature: define AD9361_TX_UNDERRUN_HOLD_EN to replay the last
// popped sample during underrun instead of emitting zeros.
module ad9361_dual_tx_axis #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PREFILL         = 8,
  parameter bit REVERSE_DATA    = 1'b0,
  parameter bit USE_AXIS_TLAST  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [127:0]             s_axis_tdata,
  input  logic                     tx_req,
  output logic                     valid_0,
  output logic                     valid_1,
  output logic                     valid_2,
  output logic                     valid_3,
  output logic [11:0]              data_i0,
  output logic [11:0]              data_q0,
  output logic [11:0]              data_i1,
  output logic [11:0]              data_q1,
  output logic [11:0]              data_i2,
  output logic [11:0]              data_q2,
  output logic [11:0]              data_i3,
  output logic [11:0]              data_q3,
  output logic                     underrun,
  input  logic                     clr_underrun,
  output logic [FIFO_DEPTH_LOG2:0] fill_level
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);

  typedef enum logic [1:0] {IDLE, FILL, RUN, UNDERRUN} state_t;

  state_t                     state;
  logic [128:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_next;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       flush;
  logic                       set_underrun;
  logic [128:0]               head;
  logic [95:0]                sample;
  logic [95:0]                filler;
  logic                       valid_q;

  // Lane k of a beat becomes sample slot k ({I0,Q0,I1,Q1,...}), low 12 bits kept.
  function automatic logic [95:0] unpack_beat(input logic [127:0] d);
    logic [127:0] r;
    logic [95:0]  s;
    for (int k = 0; k < 8; k++) begin
      r[16*k +: 16] = REVERSE_DATA ? d[16*(7-k) +: 16] : d[16*k +: 16];
      s[12*k +: 12] = r[16*k +: 12];
    end
    return s;
  endfunction

  assign full          = (count == DEPTH_C);
  assign empty         = (count == '0);
  assign flush         = ~enable;
  assign s_axis_tready = enable & ~full & ~rst;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = (state == RUN) & tx_req & ~empty & enable;
  assign head          = mem[rd_ptr];
  assign fill_level    = count;
  assign set_underrun  = enable & tx_req &
                         (((state == RUN) & empty) | (state == UNDERRUN));

  // Occupancy after this cycle; simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // Sample storage; tlast rides along as bit 128 of each entry.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  // FIFO pointers and occupancy; disabling the block discards everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

`ifdef AD9361_TX_UNDERRUN_HOLD_EN
  logic [95:0] last_pop;

  // Remember the most recent real sample so underrun can repeat it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_pop <= '0;
    else if (flush)
      last_pop <= '0;
    else if (pop)
      last_pop <= unpack_beat(head[127:0]);
  end

  assign filler = last_pop;
`else
  assign filler = '0;
`endif

  // Transmit state machine with registered sample, strobe and underrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      sample   <= '0;
      underrun <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (set_underrun)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= FILL;
          FILL: begin
            if (count_next >= PREFILL_C ||
                (USE_AXIS_TLAST && push && s_axis_tlast))
              state <= RUN;
          end
          RUN: begin
            if (tx_req) begin
              valid_q <= 1'b1;
              if (!empty) begin
                sample <= unpack_beat(head[127:0]);
                if (USE_AXIS_TLAST && head[128])
                  state <= FILL;
              end else begin
                sample <= filler;
                state  <= UNDERRUN;
              end
            end
          end
          UNDERRUN: begin
            if (tx_req) begin
              valid_q <= 1'b1;
              sample  <= filler;
            end
            if (count_next >= PREFILL_C)
              state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign valid_0 = valid_q;
  assign valid_1 = valid_q;
  assign valid_2 = valid_q;
  assign valid_3 = valid_q;
  assign data_i0 = sample[11:0];
  assign data_q0 = sample[23:12];
  assign data_i1 = sample[35:24];
  assign data_q1 = sample[47:36];
  assign data_i2 = sample[59:48];
  assign data_q2 = sample[71:60];
  assign data_i3 = sample[83:72];
  assign data_q3 = sample[95:84];

endmodule

// File: tb/tb_ad9361_dual_tx_axis.sv
// Directed bench for ad9361_dual_tx_axis: default DUT (a), lane-reversed DUT (b)
// and tlast-burst DUT (c), all driven by the same stimulus.
module tb_ad9361_dual_tx_axis;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;
  logic [127:0] tdata = '0;
  logic         tx_req = 1'b0;
  logic         clr = 1'b0;

  logic        a_tready, b_tready, c_tready;
  logic        a_underrun, b_underrun, c_underrun;
  logic [3:0]  a_valid, b_valid, c_valid;
  logic [11:0] a_di [4];
  logic [11:0] a_dq [4];
  logic [11:0] b_di [4];
  logic [11:0] b_dq [4];
  logic [11:0] c_di [4];
  logic [11:0] c_dq [4];
  logic [4:0]  a_fill, b_fill, c_fill;

  int vectors = 0;
  int miscompares = 0;

`ifdef AD9361_TX_UNDERRUN_HOLD_EN
  localparam logic [11:0] FILLER_I0 = 12'h805;
  localparam logic [11:0] FILLER_Q3 = 12'h875;
`else
  localparam logic [11:0] FILLER_I0 = 12'h000;
  localparam logic [11:0] FILLER_Q3 = 12'h000;
`endif

  ad9361_dual_tx_axis dut_a (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tvalid(tvalid), .s_axis_tready(a_tready), .s_axis_tlast(tlast),
    .s_axis_tdata(tdata), .tx_req(tx_req),
    .valid_0(a_valid[0]), .valid_1(a_valid[1]), .valid_2(a_valid[2]), .valid_3(a_valid[3]),
    .data_i0(a_di[0]), .data_q0(a_dq[0]), .data_i1(a_di[1]), .data_q1(a_dq[1]),
    .data_i2(a_di[2]), .data_q2(a_dq[2]), .data_i3(a_di[3]), .data_q3(a_dq[3]),
    .underrun(a_underrun), .clr_underrun(clr), .fill_level(a_fill)
  );

  ad9361_dual_tx_axis #(.REVERSE_DATA(1'b1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tvalid(tvalid), .s_axis_tready(b_tready), .s_axis_tlast(tlast),
    .s_axis_tdata(tdata), .tx_req(tx_req),
    .valid_0(b_valid[0]), .valid_1(b_valid[1]), .valid_2(b_valid[2]), .valid_3(b_valid[3]),
    .data_i0(b_di[0]), .data_q0(b_dq[0]), .data_i1(b_di[1]), .data_q1(b_dq[1]),
    .data_i2(b_di[2]), .data_q2(b_dq[2]), .data_i3(b_di[3]), .data_q3(b_dq[3]),
    .underrun(b_underrun), .clr_underrun(clr), .fill_level(b_fill)
  );

  ad9361_dual_tx_axis #(.USE_AXIS_TLAST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tvalid(tvalid), .s_axis_tready(c_tready), .s_axis_tlast(tlast),
    .s_axis_tdata(tdata), .tx_req(tx_req),
    .valid_0(c_valid[0]), .valid_1(c_valid[1]), .valid_2(c_valid[2]), .valid_3(c_valid[3]),
    .data_i0(c_di[0]), .data_q0(c_dq[0]), .data_i1(c_di[1]), .data_q1(c_dq[1]),
    .data_i2(c_di[2]), .data_q2(c_dq[2]), .data_i3(c_di[3]), .data_q3(c_dq[3]),
    .underrun(c_underrun), .clr_underrun(clr), .fill_level(c_fill)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Beat k: lane j = 0xF000 | k[3:0]<<8 | j<<4 | 5, except beat 1 lane 7 = 0x0123.
  function automatic logic [127:0] mk_beat(input int k);
    logic [127:0] b;
    for (int j = 0; j < 8; j++)
      b[16*j +: 16] = 16'(32'hF000 | ((k & 15) << 8) | (j << 4) | 5);
    if (k == 1)
      b[127:112] = 16'h0123;
    return b;
  endfunction

  function automatic logic [11:0] exp_i0(input int k);
    return 12'(((k & 15) << 8) | 5);
  endfunction

  function automatic logic [11:0] exp_lane7(input int k);
    return (k == 1) ? 12'h123 : 12'(((k & 15) << 8) | 32'h75);
  endfunction

  // Drive one cycle's worth of inputs and wait until just after the next edge.
  task automatic applyStimulus(input logic en, input logic tv, input logic [127:0] d,
                               input logic tl, input logic req, input logic cl);
    enable = en;
    tvalid = tv;
    tdata  = d;
    tlast  = tl;
    tx_req = req;
    clr    = cl;
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset with enable high: tready must still be held low.
    rst = 1'b1;
    enable = 1'b1;
    #12;
    checkOutput("rst_tready", 32'(a_tready), 32'd0);
    checkOutput("rst_fill", 32'(a_fill), 32'd0);
    checkOutput("rst_valid", 32'(a_valid), 32'd0);
    checkOutput("rst_underrun", 32'(a_underrun), 32'd0);
    checkOutput("rst_data_i0", 32'(a_di[0]), 32'd0);
    checkOutput("rst_data_q3", 32'(a_dq[3]), 32'd0);

    enable = 1'b0;
    tvalid = 1'b1;
    tdata = mk_beat(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, mk_beat(1), 1'b0, 1'b0, 1'b0);
    checkOutput("disabled_no_accept", 32'(a_fill), 32'd0);
    checkOutput("disabled_tready", 32'(a_tready), 32'd0);

    // Prefill seven beats; a tx_req while filling is ignored.
    for (int k = 1; k <= 7; k++)
      applyStimulus(1'b1, 1'b1, mk_beat(k), 1'b0, 1'b0, 1'b0);
    checkOutput("fill7_level", 32'(a_fill), 32'd7);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("fill_req_valid", 32'(a_valid), 32'd0);
    checkOutput("fill_req_hold", 32'(a_di[0]), 32'd0);
    checkOutput("fill_req_level", 32'(a_fill), 32'd7);
    applyStimulus(1'b1, 1'b1, mk_beat(8), 1'b0, 1'b0, 1'b0);
    checkOutput("fill8_level", 32'(a_fill), 32'd8);

    // Eight requests, one every four cycles; valid follows one cycle later.
    for (int p = 1; p <= 8; p++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("run%0d_valid", p), 32'(a_valid), 32'hF);
      checkOutput($sformatf("run%0d_i0", p), 32'(a_di[0]), 32'(exp_i0(p)));
      checkOutput($sformatf("run%0d_q3", p), 32'(a_dq[3]), 32'(exp_lane7(p)));
      checkOutput($sformatf("rev%0d_i0", p), 32'(b_di[0]), 32'(exp_lane7(p)));
      checkOutput($sformatf("run%0d_fill", p), 32'(a_fill), 32'(8 - p));
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("run%0d_pulse_end", p), 32'(a_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end

    // Ninth request finds the FIFO empty.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("ur_valid", 32'(a_valid), 32'hF);
    checkOutput("ur_flag", 32'(a_underrun), 32'd1);
    checkOutput("ur_i0", 32'(a_di[0]), 32'(FILLER_I0));
    checkOutput("ur_q3", 32'(a_dq[3]), 32'(FILLER_Q3));
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ur_clear", 32'(a_underrun), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("ur_set_priority", 32'(a_underrun), 32'd1);
    checkOutput("ur_req_valid", 32'(a_valid), 32'hF);

    // Fill to capacity while in underrun; extra beats are refused.
    for (int k = 9; k <= 24; k++)
      applyStimulus(1'b1, 1'b1, mk_beat(k), 1'b0, 1'b0, 1'b0);
    checkOutput("full_level", 32'(a_fill), 32'd16);
    checkOutput("full_tready", 32'(a_tready), 32'd0);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 1'b1, mk_beat(25), 1'b0, 1'b0, 1'b0);
    checkOutput("full_persist", 32'(a_fill), 32'd16);
    checkOutput("full_tready_hold", 32'(a_tready), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("full_pop_i0", 32'(a_di[0]), 32'(exp_i0(9)));
    checkOutput("full_pop_level", 32'(a_fill), 32'd15);
    applyStimulus(1'b1, 1'b1, mk_beat(25), 1'b0, 1'b1, 1'b0);
    checkOutput("pushpop_level", 32'(a_fill), 32'd15);
    checkOutput("pushpop_i0", 32'(a_di[0]), 32'(exp_i0(10)));

    // Drain to five, then drop enable.
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_level", 32'(a_fill), 32'd5);
    applyStimulus(1'b0, 1'b1, mk_beat(25), 1'b0, 1'b0, 1'b0);
    checkOutput("flush_level", 32'(a_fill), 32'd0);
    checkOutput("flush_tready", 32'(a_tready), 32'd0);
    checkOutput("flush_valid", 32'(a_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("tl_clear_ur", 32'(c_underrun), 32'd0);

    // Three-beat tlast burst on the tlast-aware instance.
    applyStimulus(1'b1, 1'b1, mk_beat(26), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, mk_beat(27), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, mk_beat(28), 1'b1, 1'b0, 1'b0);
    checkOutput("tl_fill", 32'(c_fill), 32'd3);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("tl_pop%0d_valid", p), 32'(c_valid), 32'hF);
      checkOutput($sformatf("tl_pop%0d_i0", p), 32'(c_di[0]), 32'(exp_i0(26 + p)));
      checkOutput($sformatf("tl_pop%0d_ur", p), 32'(c_underrun), 32'd0);
      checkOutput($sformatf("tl_pop%0d_a_ignored", p), 32'(a_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("tl_refill_valid", 32'(c_valid), 32'd0);
    checkOutput("tl_refill_ur", 32'(c_underrun), 32'd0);
    checkOutput("tl_refill_fill", 32'(c_fill), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
